// File: rtl/dvsd_pe_rr.sv
// Parametrised priority encoder with a selectable round-robin mode and a
// registered valid/ready output stage (latency 1, one result per cycle).
module dvsd_pe_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         en,
  input  logic         rr_en,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         gs,
  output logic         eno,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_ptr;
  logic [W-1:0] r_out;
  logic         r_gs;
  logic         r_eno;
  logic         r_valid;

  logic [W-1:0] w_fix_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_scan;
  logic         w_rr_hit;
  logic [W-1:0] w_win;
  logic [W-1:0] w_out;
  logic         w_any;
  logic         w_gs;
  logic         w_eno;
  logic         w_accept;

  // Fixed priority: the last set bit seen while scanning upward wins.
  always_comb begin
    w_fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) w_fix_idx = W'(i);
    end
  end

  // Round-robin: scan downward from the pointer, wrapping 0 -> N-1.
  always_comb begin
    w_rr_idx = '0;
    w_rr_hit = 1'b0;
    w_scan   = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_rr_hit && in[w_scan]) begin
        w_rr_idx = w_scan;
        w_rr_hit = 1'b1;
      end
      w_scan = (w_scan == '0) ? LAST : w_scan - 1'b1;
    end
  end

  assign w_any    = |in;
  assign w_win    = rr_en ? w_rr_idx : w_fix_idx;
  assign w_gs     = en && w_any;
  assign w_eno    = en && !w_any;
  assign w_out    = w_gs ? w_win : '0;
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_gs    <= 1'b0;
      r_eno   <= 1'b0;
      r_ptr   <= LAST;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_out   <= w_out;
      r_gs    <= w_gs;
      r_eno   <= w_eno;
      // The granted request drops to lowest priority for the next search.
      if (rr_en && w_gs) begin
        r_ptr <= (w_win == '0) ? LAST : w_win - 1'b1;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign gs        = r_gs;
  assign eno       = r_eno;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_dvsd_pe_rr.sv
// Directed bench for dvsd_pe_rr (N=8): expected results are queued when a
// transfer is accepted and compared when the result is consumed.
module tb_dvsd_pe_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       en;
  logic       rr_en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out;
  logic       gs;
  logic       eno;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;
  logic [4:0] sb_q[$];

  always #5 clk = ~clk;

  dvsd_pe_rr #(.N(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .en(en),
    .rr_en(rr_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(out),
    .gs(gs),
    .eno(eno),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive after the falling edge, score just before the rising edge.
  task automatic step(input logic [7:0] vin, input logic ven, input logic vrr,
                      input logic vval, input logic vrdy,
                      input logic [2:0] eo, input logic eg, input logic ee);
    logic [4:0] got;
    @(negedge clk);
    in        = vin;
    en        = ven;
    rr_en     = vrr;
    in_valid  = vval;
    out_ready = vrdy;
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_result", 32'(out), 32'hFFFF_FFFF);
        end else begin
          got = sb_q.pop_front();
          chk("result_out", 32'(out), 32'(got[4:2]));
          chk("result_gs",  32'(gs),  32'(got[1]));
          chk("result_eno", 32'(eno), 32'(got[0]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({eo, eg, ee});
    end
    @(posedge clk);
    if (!rst_n) sb_q.delete();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in = '0; en = 1'b0; rr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out",       32'(out),       32'd0);
    chk("rst_gs",        32'(gs),        32'd0);
    chk("rst_eno",       32'(eno),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Fixed mode: disabled, then every one-hot request.
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("latency_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(8'(1 << i), 1'b1, 1'b0, 1'b1, 1'b1, 3'(i), 1'b1, 1'b0);
    end
    step(8'b1010_0110, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    step(8'h00,        1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);

    // Round-robin rotation: 7,4,1,7 leaves the pointer at 6.
    step(8'b1001_0010, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    step(8'b1001_0010, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(8'b1001_0010, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(8'b1001_0010, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    // A fixed-mode grant must not move the pointer.
    step(8'b0000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(8'hFF,        1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);

    // Backpressure: result 2 pending while the sink stalls.
    step(8'b0000_0100, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'b0000_1000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out",       32'(out),       32'd2);
      chk("bp_gs",        32'(gs),        32'd1);
      chk("bp_eno",       32'(eno),       32'd0);
    end
    step(8'b0000_1000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_out", 32'(out), 32'd3);

    // Pointer is 5: grant index 0 wraps it to 7.
    step(8'b0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    step(8'hFF,        1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    // Disabled and empty round-robin transfers leave the pointer at 6.
    step(8'hFF,        1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    step(8'h00,        1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    step(8'hFF,        1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);

    // Grant 4 (pointer becomes 3), stall it, then reset drops it.
    step(8'b0001_0000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("pend_out", 32'(out), 32'd4);
    rst_n = 1'b0;
    step(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_gs",       32'(gs),        32'd0);
    chk("mid_rst_eno",      32'(eno),       32'd0);
    chk("mid_rst_out",      32'(out),       32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
    step(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("final_valid", 32'(out_valid), 32'd0);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
